// File: rtl/riscV_unrn_pkg.sv
// Shared trap definitions: mcause codes, memory access encodings, trap FSM states
// and the default address windows used by trap_ctrl.
package riscV_unrn_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'b0000,
    MEM_LB   = 4'b1000,
    MEM_LH   = 4'b1001,
    MEM_LW   = 4'b1010,
    MEM_SB   = 4'b1100,
    MEM_SH   = 4'b1101,
    MEM_SW   = 4'b1110
  } mem_inst_type_t;

  localparam logic [31:0] M_INSTR_MISALIGN = 32'd0;
  localparam logic [31:0] M_INSTR_AFAULT   = 32'd1;
  localparam logic [31:0] M_ILLEGAL_INSTR  = 32'd2;
  localparam logic [31:0] M_BREAKPOINT     = 32'd3;
  localparam logic [31:0] M_LOAD_MISALIGN  = 32'd4;
  localparam logic [31:0] M_LOAD_AFAULT    = 32'd5;
  localparam logic [31:0] M_STORE_MISALIGN = 32'd6;
  localparam logic [31:0] M_STORE_AFAULT   = 32'd7;

  localparam logic [30:0] M_TIMER_IRQ      = 31'd7;
  localparam logic [30:0] M_LOCAL_IRQ_BASE = 31'd16;

  localparam logic [31:0] DEF_PC_BASE   = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_LIMIT  = 32'h0000_FFFF;
  localparam logic [31:0] DEF_MEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_MEM_LIMIT = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HANDLER = 2'd1,
    ST_HALT    = 2'd2
  } trap_state_t;

  // Channel 0 is the machine timer; local channels start at code 16.
  function automatic logic [30:0] irq_code(input logic [31:0] idx);
    return (idx == 32'd0) ? M_TIMER_IRQ : (M_LOCAL_IRQ_BASE + idx[30:0] - 31'd1);
  endfunction

  // Inclusive window test done as one unsigned compare, so a zero base is not a constant compare.
  function automatic logic in_range(input logic [31:0] a, input logic [31:0] base,
                                    input logic [31:0] limit);
    return (a - base) <= (limit - base);
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_pending.sv
// Per-channel interrupt capture (edge or level), clear-on-take and a
// lowest-index-wins priority encoder over the enabled pending set.
module trap_ctrl_irq_pending #(
  parameter int                 N_IRQ         = 4,
  parameter logic [N_IRQ-1:0]   IRQ_EDGE_MASK = '0,
  parameter int                 IDX_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] mie_i,
  input  logic             take_i,
  output logic [N_IRQ-1:0] pending_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [N_IRQ-1:0] irq_q, pending_q, pending_d, masked, take_mask;

  always_comb begin
    masked    = pending_q & mie_i;
    valid_o   = |masked;
    idx_o     = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (masked[k]) idx_o = IDX_W'(k);
    end
    take_mask = '0;
    if (take_i) take_mask[idx_o] = 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_chan
      if (IRQ_EDGE_MASK[gi]) begin : g_edge
        // A fresh edge in the take cycle keeps the bit set.
        assign pending_d[gi] = (pending_q[gi] & ~take_mask[gi]) | (irq_i[gi] & ~irq_q[gi]);
      end else begin : g_level
        assign pending_d[gi] = irq_i[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: synchronous exception detection, interrupt arbitration,
// registered trap-entry payload and nested-handler depth tracking.
module trap_ctrl
  import riscV_unrn_pkg::*;
#(
  parameter int               N_IRQ         = 4,
  parameter logic [N_IRQ-1:0] IRQ_EDGE_MASK = '0,
  parameter int               MAX_NEST      = 2,
  parameter logic [31:0]      PC_BASE       = DEF_PC_BASE,
  parameter logic [31:0]      PC_LIMIT      = DEF_PC_LIMIT,
  parameter logic [31:0]      MEM_BASE      = DEF_MEM_BASE,
  parameter logic [31:0]      MEM_LIMIT     = DEF_MEM_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic [31:0]                   pc_i,
  input  logic                          should_jump_i,
  input  logic [31:0]                   pc_jump_dst_i,
  input  logic [31:0]                   data_addr_i,
  input  mem_inst_type_t                mem_type_i,
  input  logic                          inst_invalid_i,
  input  logic                          priv_exc_i,
  input  logic [31:0]                   priv_cause_i,
  input  logic                          mret_i,
  input  logic [N_IRQ-1:0]              irq_i,
  input  logic [N_IRQ-1:0]              mie_i,
  input  logic                          mstatus_mie_i,
  input  logic [31:0]                   mtvec_i,
  output logic                          trap_o,
  output logic [31:0]                   trap_cause_o,
  output logic [31:0]                   trap_val_o,
  output logic [31:0]                   epc_o,
  output logic [31:0]                   trap_pc_o,
  output logic [N_IRQ-1:0]              irq_pending_o,
  output logic [$clog2(MAX_NEST+1)-1:0] nest_o,
  output logic                          halted_o
);

  localparam int NW    = $clog2(MAX_NEST + 1);
  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  trap_state_t state_q, state_d;
  logic        trap_q, trap_d, halted_q, halted_d;
  logic [31:0] cause_q, cause_d, tval_q, tval_d, epc_q, epc_d, tpc_q, tpc_d;
  logic [NW-1:0] nest_q, nest_d;

  logic             irq_valid, irq_take;
  logic [IDX_W-1:0] irq_idx;
  logic [30:0]      code;
  logic [31:0]      base;
  logic             exc, exc_hit, is_load, is_store, misalign;
  logic [31:0]      exc_cause, exc_tval;

  trap_ctrl_irq_pending #(
    .N_IRQ(N_IRQ), .IRQ_EDGE_MASK(IRQ_EDGE_MASK), .IDX_W(IDX_W)
  ) u_irq (
    .clk(clk), .rst(rst), .irq_i(irq_i), .mie_i(mie_i), .take_i(irq_take),
    .pending_o(irq_pending_o), .valid_o(irq_valid), .idx_o(irq_idx)
  );

  assign irq_take = (state_q == ST_IDLE) && valid_i && mstatus_mie_i && irq_valid;
  assign code     = irq_code(32'(irq_idx));
  assign base     = {mtvec_i[31:2], 2'b00};

  always_comb begin
    is_load   = (mem_type_i == MEM_LB) || (mem_type_i == MEM_LH) || (mem_type_i == MEM_LW);
    is_store  = (mem_type_i == MEM_SB) || (mem_type_i == MEM_SH) || (mem_type_i == MEM_SW);
    misalign  = (((mem_type_i == MEM_LH) || (mem_type_i == MEM_SH)) && data_addr_i[0]) ||
                (((mem_type_i == MEM_LW) || (mem_type_i == MEM_SW)) && (data_addr_i[1:0] != 2'b00));
    exc_hit   = 1'b1;
    exc_cause = '0;
    exc_tval  = pc_i;
    if (should_jump_i && (pc_jump_dst_i[1:0] != 2'b00)) begin
      exc_cause = M_INSTR_MISALIGN;
      exc_tval  = pc_jump_dst_i;
    end else if (!in_range(pc_i, PC_BASE, PC_LIMIT)) begin
      exc_cause = M_INSTR_AFAULT;
    end else if (inst_invalid_i) begin
      exc_cause = M_ILLEGAL_INSTR;
    end else if (priv_exc_i) begin
      exc_cause = priv_cause_i;
    end else if ((is_load || is_store) && !in_range(data_addr_i, MEM_BASE, MEM_LIMIT)) begin
      exc_cause = is_load ? M_LOAD_AFAULT : M_STORE_AFAULT;
      exc_tval  = data_addr_i;
    end else if ((is_load || is_store) && misalign) begin
      exc_cause = is_load ? M_LOAD_MISALIGN : M_STORE_MISALIGN;
      exc_tval  = data_addr_i;
    end else begin
      exc_hit   = 1'b0;
    end
    exc = valid_i && exc_hit;
  end

  always_comb begin
    state_d  = state_q;
    trap_d   = 1'b0;
    cause_d  = cause_q;
    tval_d   = tval_q;
    epc_d    = epc_q;
    tpc_d    = tpc_q;
    nest_d   = nest_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (irq_take) begin
          trap_d  = 1'b1;
          cause_d = {1'b1, code};
          tval_d  = '0;
          epc_d   = pc_i;
          tpc_d   = (mtvec_i[1:0] == 2'b01) ? (base + {code[29:0], 2'b00}) : base;
          nest_d  = NW'(1);
          state_d = ST_HANDLER;
        end else if (exc) begin
          trap_d  = 1'b1;
          cause_d = exc_cause;
          tval_d  = exc_tval;
          epc_d   = pc_i;
          tpc_d   = base;
          nest_d  = NW'(1);
          state_d = ST_HANDLER;
        end
      end
      ST_HANDLER: begin
        if (exc) begin
          if (nest_q < NW'(MAX_NEST)) begin
            trap_d  = 1'b1;
            cause_d = exc_cause;
            tval_d  = exc_tval;
            epc_d   = pc_i;
            tpc_d   = base;
            nest_d  = nest_q + NW'(1);
          end else begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end else if (mret_i) begin
          nest_d = nest_q - NW'(1);
          if (nest_q == NW'(1)) state_d = ST_IDLE;
        end
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trap_q   <= 1'b0;
      cause_q  <= '0;
      tval_q   <= '0;
      epc_q    <= '0;
      tpc_q    <= '0;
      nest_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      epc_q    <= epc_d;
      tpc_q    <= tpc_d;
      nest_q   <= nest_d;
      halted_q <= halted_d;
    end
  end

  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;
  assign trap_val_o   = tval_q;
  assign epc_o        = epc_q;
  assign trap_pc_o    = tpc_q;
  assign nest_o       = nest_q;
  assign halted_o     = halted_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: exception vector table plus hand-written
// interrupt, nesting, halt and reset sequences.
module tb_trap_ctrl;
  import riscV_unrn_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_i, should_jump_i, inst_invalid_i, priv_exc_i, mret_i, mstatus_mie_i;
  logic [31:0]    pc_i, pc_jump_dst_i, data_addr_i, priv_cause_i, mtvec_i;
  mem_inst_type_t mem_type_i;
  logic [3:0]     irq_i, mie_i;
  logic           trap_o, halted_o;
  logic [31:0]    trap_cause_o, trap_val_o, epc_o, trap_pc_o;
  logic [3:0]     irq_pending_o;
  logic [1:0]     nest_o;

  int tests = 0;
  int fails = 0;

  trap_ctrl #(.N_IRQ(4), .IRQ_EDGE_MASK(4'b1110), .MAX_NEST(2)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
    .should_jump_i(should_jump_i), .pc_jump_dst_i(pc_jump_dst_i),
    .data_addr_i(data_addr_i), .mem_type_i(mem_type_i),
    .inst_invalid_i(inst_invalid_i), .priv_exc_i(priv_exc_i),
    .priv_cause_i(priv_cause_i), .mret_i(mret_i), .irq_i(irq_i), .mie_i(mie_i),
    .mstatus_mie_i(mstatus_mie_i), .mtvec_i(mtvec_i), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .trap_val_o(trap_val_o), .epc_o(epc_o),
    .trap_pc_o(trap_pc_o), .irq_pending_o(irq_pending_o), .nest_o(nest_o),
    .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        jump;
    logic [31:0] dst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  mtype;
    logic        ill;
    logic        priv;
    logic [31:0] pcause;
    logic        exp_trap;
    logic [31:0] exp_cause;
    logic [31:0] exp_tval;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    valid_i        = 1'b0;
    should_jump_i  = 1'b0;
    pc_jump_dst_i  = 32'h0;
    pc_i           = 32'h1000;
    data_addr_i    = 32'h0;
    mem_type_i     = MEM_NONE;
    inst_invalid_i = 1'b0;
    priv_exc_i     = 1'b0;
    priv_cause_i   = 32'h0;
    mret_i         = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_trap"},    {31'b0, trap_o}, 32'h0);
    chk({tag, "_cause"},   trap_cause_o, 32'h0);
    chk({tag, "_tval"},    trap_val_o, 32'h0);
    chk({tag, "_epc"},     epc_o, 32'h0);
    chk({tag, "_tpc"},     trap_pc_o, 32'h0);
    chk({tag, "_pending"}, {28'b0, irq_pending_o}, 32'h0);
    chk({tag, "_nest"},    {30'b0, nest_o}, 32'h0);
    chk({tag, "_halted"},  {31'b0, halted_o}, 32'h0);
  endtask

  initial begin
    //        name        vld jmp dst          pc            addr          type  ill priv pcause trap cause  tval
    vecs[0]  = '{"jmp_mis",  1, 1, 32'h2002, 32'h1000,  32'h0,     4'b0000, 1, 0, 0,  1, 32'd0,  32'h2002};
    vecs[1]  = '{"pc_oor",   1, 0, 32'h0,    32'h10000, 32'h0,     4'b0000, 1, 0, 0,  1, 32'd1,  32'h10000};
    vecs[2]  = '{"illegal",  1, 0, 32'h0,    32'h1010,  32'h0,     4'b0000, 1, 1, 11, 1, 32'd2,  32'h1010};
    vecs[3]  = '{"ecall",    1, 0, 32'h0,    32'h1020,  32'h20000, 4'b1110, 0, 1, 11, 1, 32'd11, 32'h1020};
    vecs[4]  = '{"lw_mis",   1, 0, 32'h0,    32'h1030,  32'h102,   4'b1010, 0, 0, 0,  1, 32'd4,  32'h102};
    vecs[5]  = '{"sh_mis",   1, 0, 32'h0,    32'h1040,  32'h201,   4'b1101, 0, 0, 0,  1, 32'd6,  32'h201};
    vecs[6]  = '{"lb_odd",   1, 0, 32'h0,    32'h1050,  32'h203,   4'b1000, 0, 0, 0,  0, 32'd0,  32'h0};
    vecs[7]  = '{"lh_af",    1, 0, 32'h0,    32'h1060,  32'h20000, 4'b1001, 0, 0, 0,  1, 32'd5,  32'h20000};
    vecs[8]  = '{"sw_af",    1, 0, 32'h0,    32'h1070,  32'h20001, 4'b1110, 0, 0, 0,  1, 32'd7,  32'h20001};
    vecs[9]  = '{"bad_type", 1, 0, 32'h0,    32'h1080,  32'h3,     4'b1011, 0, 0, 0,  0, 32'd0,  32'h0};
    vecs[10] = '{"no_valid", 0, 0, 32'h0,    32'h1090,  32'h0,     4'b0000, 1, 0, 0,  0, 32'd0,  32'h0};
    vecs[11] = '{"edge_ok",  1, 0, 32'h0,    32'hFFFF,  32'hFFFC,  4'b1010, 0, 0, 0,  0, 32'd0,  32'h0};
    vecs[12] = '{"sb_lim",   1, 1, 32'h2004, 32'hFFFC,  32'hFFFF,  4'b1100, 0, 0, 0,  0, 32'd0,  32'h0};

    clr_in();
    rst = 1'b1; irq_i = 4'h0; mie_i = 4'h0; mstatus_mie_i = 1'b0; mtvec_i = 32'h100;
    step(); step();
    rst = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 13; i++) begin
      clr_in();
      valid_i = vecs[i].valid; should_jump_i = vecs[i].jump; pc_jump_dst_i = vecs[i].dst;
      pc_i = vecs[i].pc; data_addr_i = vecs[i].addr; mem_type_i = mem_inst_type_t'(vecs[i].mtype);
      inst_invalid_i = vecs[i].ill; priv_exc_i = vecs[i].priv; priv_cause_i = vecs[i].pcause;
      step();
      chk({vecs[i].name, "_trap"}, {31'b0, trap_o}, {31'b0, vecs[i].exp_trap});
      if (vecs[i].exp_trap) begin
        chk({vecs[i].name, "_cause"}, trap_cause_o, vecs[i].exp_cause);
        chk({vecs[i].name, "_tval"},  trap_val_o, vecs[i].exp_tval);
        chk({vecs[i].name, "_epc"},   epc_o, vecs[i].pc);
        chk({vecs[i].name, "_tpc"},   trap_pc_o, 32'h100);
        chk({vecs[i].name, "_nest"},  {30'b0, nest_o}, 32'd1);
        clr_in(); mret_i = 1'b1;
        step();
        chk({vecs[i].name, "_ret"},   {30'b0, nest_o}, 32'd0);
      end else begin
        chk({vecs[i].name, "_nest"},  {30'b0, nest_o}, 32'd0);
      end
      $display("[TB] vector %0d %s trap=%0b cause=%h tval=%h", i, vecs[i].name, vecs[i].exp_trap,
               vecs[i].exp_cause, vecs[i].exp_tval);
    end

    // Vectored interrupt beats an illegal instruction in the same cycle.
    clr_in(); mtvec_i = 32'h201; mstatus_mie_i = 1'b1; mie_i = 4'hF; irq_i = 4'b0100;
    step();
    chk("vec_pend_set", {28'b0, irq_pending_o}, 32'h4);
    valid_i = 1'b1; inst_invalid_i = 1'b1;
    step();
    chk("vec_trap",  {31'b0, trap_o}, 32'h1);
    chk("vec_cause", trap_cause_o, 32'h8000_0011);
    chk("vec_tpc",   trap_pc_o, 32'h244);
    chk("vec_tval",  trap_val_o, 32'h0);
    chk("vec_epc",   epc_o, 32'h1000);
    chk("vec_pend_clr", {28'b0, irq_pending_o}, 32'h0);
    $display("[TB] seq vectored irq cause=%h tpc=%h", trap_cause_o, trap_pc_o);

    // Interrupts masked inside the handler; taken after mret.
    clr_in(); valid_i = 1'b1; irq_i = 4'b0001;
    step();
    chk("mask_trap0", {31'b0, trap_o}, 32'h0);
    chk("mask_pend",  {28'b0, irq_pending_o}, 32'h1);
    step();
    chk("mask_trap1", {31'b0, trap_o}, 32'h0);
    clr_in(); mret_i = 1'b1;
    step();
    chk("mask_ret", {30'b0, nest_o}, 32'd0);
    clr_in(); valid_i = 1'b1;
    step();
    chk("timer_trap",  {31'b0, trap_o}, 32'h1);
    chk("timer_cause", trap_cause_o, 32'h8000_0007);
    chk("timer_tpc",   trap_pc_o, 32'h21C);
    chk("timer_nest",  {30'b0, nest_o}, 32'd1);
    $display("[TB] seq masked timer cause=%h", trap_cause_o);
    clr_in(); irq_i = 4'h0; mstatus_mie_i = 1'b0; mtvec_i = 32'h100; mret_i = 1'b1;
    step();
    chk("timer_ret", {30'b0, nest_o}, 32'd0);

    // Nesting to MAX_NEST, then a double fault halts.
    clr_in(); valid_i = 1'b1; inst_invalid_i = 1'b1;
    step();
    chk("nest1_cause", trap_cause_o, 32'd2);
    chk("nest1_nest",  {30'b0, nest_o}, 32'd1);
    clr_in(); valid_i = 1'b1; priv_exc_i = 1'b1; priv_cause_i = 32'd11; pc_i = 32'h1004;
    step();
    chk("nest2_trap",  {31'b0, trap_o}, 32'h1);
    chk("nest2_cause", trap_cause_o, 32'd11);
    chk("nest2_epc",   epc_o, 32'h1004);
    chk("nest2_nest",  {30'b0, nest_o}, 32'd2);
    clr_in(); valid_i = 1'b1; inst_invalid_i = 1'b1;
    step();
    chk("halt_trap",   {31'b0, trap_o}, 32'h0);
    chk("halt_flag",   {31'b0, halted_o}, 32'h1);
    chk("halt_cause",  trap_cause_o, 32'd11);
    clr_in(); valid_i = 1'b1; inst_invalid_i = 1'b1; mret_i = 1'b1; mstatus_mie_i = 1'b1; irq_i = 4'b0001;
    step();
    chk("halt_stuck",  {31'b0, halted_o}, 32'h1);
    chk("halt_notrap", {31'b0, trap_o}, 32'h0);
    chk("halt_nest",   {30'b0, nest_o}, 32'd2);
    $display("[TB] seq nesting/halt halted=%0b nest=%0d", halted_o, nest_o);
    clr_in(); irq_i = 4'h0; mstatus_mie_i = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("halt_exit", {31'b0, halted_o}, 32'h0);

    // mret and store access fault together: exception wins.
    clr_in(); valid_i = 1'b1; inst_invalid_i = 1'b1;
    step();
    clr_in(); valid_i = 1'b1; mret_i = 1'b1; mem_type_i = MEM_SW; data_addr_i = 32'h20000;
    step();
    chk("mret_af_trap",  {31'b0, trap_o}, 32'h1);
    chk("mret_af_cause", trap_cause_o, 32'd7);
    chk("mret_af_tval",  trap_val_o, 32'h20000);
    chk("mret_af_nest",  {30'b0, nest_o}, 32'd2);
    $display("[TB] seq mret+store fault cause=%h nest=%0d", trap_cause_o, nest_o);

    // Reset mid-handler clears everything, including pending edges.
    clr_in(); irq_i = 4'b1010;
    step();
    chk("pre_rst_pend", {28'b0, irq_pending_o}, 32'hA);
    chk("pre_rst_nest", {30'b0, nest_o}, 32'd2);
    rst = 1'b1; irq_i = 4'h0;
    step();
    rst = 1'b0;
    chk_reset_state("midrst");
    irq_i = 4'b0010;
    step();
    chk("post_rst_pend", {28'b0, irq_pending_o}, 32'h2);
    clr_in(); valid_i = 1'b1; inst_invalid_i = 1'b1;
    step();
    chk("post_rst_trap", {31'b0, trap_o}, 32'h1);
    chk("post_rst_nest", {30'b0, nest_o}, 32'd1);
    $display("[TB] seq reset mid-handler pending=%b", irq_pending_o);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
